uart_param_tx: RTL

Transmit-side framer for the waveform-parameter protocol. On a report request it snapshots the current `freq`/`wave` settings and sends them back to the host as a 7-byte frame through the UART transmitter's `send_en`/`send_data`/`tx_busy` handshake. It sits between the parameter registers and the UART send block, in parallel with the receive/loop path.

---
 rtl/uart_param_tx.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/uart_param_tx.sv
// Parameter report framer: on a report request, snapshots freq/wave and sends
// a 7-byte frame (head, freq x3, wave, checksum, tail) over a send_en/tx_busy UART handshake.
module uart_param_tx #(
    parameter logic [7:0]  HEAD_BYTE = 8'hAA,
    parameter logic [7:0]  TAIL_BYTE = 8'h55,
    parameter int unsigned BUSY_WAIT = 15
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        report_req,
    input  logic [23:0] freq,
    input  logic [7:0]  wave,
    input  logic        tx_busy,
    output logic        send_en,
    output logic [7:0]  send_data,
    output logic        frame_busy,
    output logic        frame_done
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(6);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(BUSY_WAIT);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STROBE,
        WAIT_BUSY,
        WAIT_IDLE,
        DONE
    } state_t;

    state_t           state;
    logic             d0;
    logic             d1;
    logic             req_flag;
    logic             pending;
    logic [IDX_W-1:0] byte_idx;
    logic [CNT_W-1:0] wait_cnt;
    logic [23:0]      freq_q;
    logic [7:0]       wave_q;
    logic [7:0]       sum_q;
    logic [7:0]       sum_c;
    logic [7:0]       byte_c;
    logic             byte_sent_c;

    assign req_flag = d0 & ~d1;
    assign sum_c    = freq[23:16] + freq[15:8] + freq[7:0] + wave;

    // A byte is finished when the transmitter goes idle, or when it never
    // acknowledged the strobe within BUSY_WAIT cycles.
    assign byte_sent_c = !tx_busy &&
                         ((state == WAIT_IDLE) ||
                          (state == WAIT_BUSY && wait_cnt == WAIT_MAX));

    always_comb begin
        byte_c = TAIL_BYTE;
        case (byte_idx)
            IDX_W'(0): byte_c = HEAD_BYTE;
            IDX_W'(1): byte_c = freq_q[23:16];
            IDX_W'(2): byte_c = freq_q[15:8];
            IDX_W'(3): byte_c = freq_q[7:0];
            IDX_W'(4): byte_c = wave_q;
            IDX_W'(5): byte_c = sum_q;
            default:   byte_c = TAIL_BYTE;
        endcase
    end

    // Request synchroniser / edge detector
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            d0 <= 1'b0;
            d1 <= 1'b0;
        end else begin
            d0 <= report_req;
            d1 <= d0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            pending    <= 1'b0;
            byte_idx   <= '0;
            wait_cnt   <= '0;
            freq_q     <= '0;
            wave_q     <= '0;
            sum_q      <= '0;
            send_en    <= 1'b0;
            send_data  <= 8'h00;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            send_en <= 1'b0;
            if (req_flag && state != IDLE) begin
                pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (req_flag || pending) begin
                        freq_q     <= freq;
                        wave_q     <= wave;
                        sum_q      <= sum_c;
                        byte_idx   <= '0;
                        pending    <= 1'b0;
                        frame_busy <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    send_data <= byte_c;
                    state     <= STROBE;
                end
                STROBE: begin
                    send_en  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_IDLE;
                    end else if (wait_cnt != WAIT_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                end
                DONE: begin
                    frame_done <= 1'b0;
                    frame_busy <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Shared exit for both wait states
            if (byte_sent_c) begin
                if (byte_idx == LAST_IDX) begin
                    frame_done <= 1'b1;
                    state      <= DONE;
                end else begin
                    byte_idx <= byte_idx + 1'b1;
                    state    <= LOAD;
                end
            end
        end
    end
endmodule
